pattern_stim_driver: RTL and testbench

- Tester-side counterpart of the two-input, one-output `simple` netlist interface.
- Drives `inp1`/`inp2` from parallel stimulus words and samples `out` back into a parallel response word.
- Sits between a stimulus source (valid/ready) and the DUT netlist, and returns results over a valid/ready channel.
- Used to exercise original and enhanced netlists with identical patterns for equivalence checks.

---
 rtl/pattern_stim_pkg.sv | 18 +
 rtl/stim_shift_lane.sv | 27 ++
 rtl/pattern_stim_driver.sv | 139 +++++++++++++
 tb/tb_pattern_stim_driver.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/pattern_stim_pkg.sv
// Shared types and limits for the pattern stimulus driver and its shift lanes.
package pattern_stim_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRIVE = 2'd1,
    RESP  = 2'd2
  } state_t;

  localparam int MAX_VEC_LEN = 64;
  localparam int MAX_SETTLE  = 255;

  // Index width for an n-entry range; never narrower than one bit.
  function automatic int idx_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/stim_shift_lane.sv
// Loadable right-shift register; lsb_o presents the bit due to be driven next.
module stim_shift_lane #(
  parameter int VEC_LEN = 8
) (
  input  logic               clk_i,
  input  logic               rst_n_i,
  input  logic               load_i,
  input  logic [VEC_LEN-1:0] load_val_i,
  input  logic               shift_i,
  output logic               lsb_o
);

  logic [VEC_LEN-1:0] sr_q;

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      sr_q <= '0;
    end else if (load_i) begin
      sr_q <= load_val_i;
    end else if (shift_i) begin
      sr_q <= sr_q >> 1;
    end
  end

  assign lsb_o = sr_q[0];

endmodule

// File: rtl/pattern_stim_driver.sv
// Serialises stimulus word pairs onto a two-input netlist, holds each pair for
// SETTLE_CYC cycles, and gathers the sampled output into a response word.
module pattern_stim_driver
  import pattern_stim_pkg::*;
#(
  parameter int VEC_LEN    = 8,
  parameter int SETTLE_CYC = 2
) (
  input  logic               iccad_clk,
  input  logic               iccad_rst_n,
  input  logic [VEC_LEN-1:0] vec_a,
  input  logic [VEC_LEN-1:0] vec_b,
  input  logic               vec_valid,
  output logic               vec_ready,
  output logic               drv_inp1,
  output logic               drv_inp2,
  input  logic               dut_out,
  output logic [VEC_LEN-1:0] rsp_data,
  output logic               rsp_valid,
  input  logic               rsp_ready,
  output logic               busy,
  output state_t             dbg_state
);

  // Handshakes: a word moves on any rising edge where valid and ready are both
  // high; valid is never retracted by this block until that edge.
  localparam int BW = idx_width(VEC_LEN);
  localparam int SW = $clog2(SETTLE_CYC + 1);
  localparam logic [BW-1:0] LAST_BIT    = BW'(VEC_LEN - 1);
  localparam logic [SW-1:0] LAST_SETTLE = SW'(SETTLE_CYC - 1);

  if (VEC_LEN < 1 || VEC_LEN > MAX_VEC_LEN ||
      SETTLE_CYC < 1 || SETTLE_CYC > MAX_SETTLE) begin : g_bad_param
    $error("pattern_stim_driver: VEC_LEN or SETTLE_CYC out of range");
  end

  state_t             state_q;
  logic [SW-1:0]      settle_q;
  logic [BW-1:0]      bit_idx_q;
  logic [VEC_LEN-1:0] rsp_data_q;
  logic               rsp_valid_q;
  logic               vec_ready_q;
  logic               busy_q;
  logic               drv1_q;
  logic               drv2_q;

  logic accept;
  logic last_settle;
  logic advance;
  logic lane_a_lsb;
  logic lane_b_lsb;

  assign accept      = (state_q == IDLE) && vec_valid;
  assign last_settle = (settle_q == LAST_SETTLE);
  assign advance     = (state_q == DRIVE) && last_settle && (bit_idx_q != LAST_BIT);

  // Bit 0 goes straight to the drive flops, so the lanes hold only the rest.
  stim_shift_lane #(.VEC_LEN(VEC_LEN)) u_lane_a (
    .clk_i      (iccad_clk),
    .rst_n_i    (iccad_rst_n),
    .load_i     (accept),
    .load_val_i (vec_a >> 1),
    .shift_i    (advance),
    .lsb_o      (lane_a_lsb)
  );

  stim_shift_lane #(.VEC_LEN(VEC_LEN)) u_lane_b (
    .clk_i      (iccad_clk),
    .rst_n_i    (iccad_rst_n),
    .load_i     (accept),
    .load_val_i (vec_b >> 1),
    .shift_i    (advance),
    .lsb_o      (lane_b_lsb)
  );

  always_ff @(posedge iccad_clk) begin
    if (!iccad_rst_n) begin
      state_q     <= IDLE;
      settle_q    <= '0;
      bit_idx_q   <= '0;
      rsp_data_q  <= '0;
      rsp_valid_q <= 1'b0;
      vec_ready_q <= 1'b1;
      busy_q      <= 1'b0;
      drv1_q      <= 1'b0;
      drv2_q      <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (vec_valid) begin
            drv1_q      <= vec_a[0];
            drv2_q      <= vec_b[0];
            settle_q    <= '0;
            bit_idx_q   <= '0;
            vec_ready_q <= 1'b0;
            busy_q      <= 1'b1;
            state_q     <= DRIVE;
          end
        end
        DRIVE: begin
          if (last_settle) begin
            rsp_data_q[bit_idx_q] <= dut_out;
            settle_q              <= '0;
            if (bit_idx_q != LAST_BIT) begin
              bit_idx_q <= bit_idx_q + 1'b1;
              drv1_q    <= lane_a_lsb;
              drv2_q    <= lane_b_lsb;
            end else begin
              drv1_q      <= 1'b0;
              drv2_q      <= 1'b0;
              rsp_valid_q <= 1'b1;
              state_q     <= RESP;
            end
          end else begin
            settle_q <= settle_q + 1'b1;
          end
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid_q <= 1'b0;
            vec_ready_q <= 1'b1;
            busy_q      <= 1'b0;
            state_q     <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign vec_ready = vec_ready_q;
  assign drv_inp1  = drv1_q;
  assign drv_inp2  = drv2_q;
  assign rsp_data  = rsp_data_q;
  assign rsp_valid = rsp_valid_q;
  assign busy      = busy_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_pattern_stim_driver.sv
// Bench for pattern_stim_driver with an XOR loopback netlist on three configurations.
module tb_pattern_stim_driver;
  import pattern_stim_pkg::*;

  logic iccad_clk = 1'b0;
  always #5 iccad_clk = ~iccad_clk;

  // Instances 0 (VEC_LEN=8, SETTLE=1) and 1 (VEC_LEN=8, SETTLE=3)
  logic       rst_n [2];
  logic [7:0] va [2];
  logic [7:0] vb [2];
  logic [7:0] rd [2];
  logic       vv [2];
  logic       vr [2];
  logic       d1 [2];
  logic       d2 [2];
  logic       rv [2];
  logic       rr [2];
  logic       bz [2];
  state_t     st [2];
  logic       dout0, dout1;

  // Instance C (VEC_LEN=1, SETTLE=1)
  logic   c_rst_n, c_va, c_vb, c_vv, c_vr, c_d1, c_d2, c_dout, c_rd, c_rv, c_rr, c_bz;
  state_t c_st;

  assign dout0  = d1[0] ^ d2[0];
  assign dout1  = d1[1] ^ d2[1];
  assign c_dout = c_d1 ^ c_d2;

  pattern_stim_driver #(.VEC_LEN(8), .SETTLE_CYC(1)) u_a (
    .iccad_clk(iccad_clk), .iccad_rst_n(rst_n[0]), .vec_a(va[0]), .vec_b(vb[0]),
    .vec_valid(vv[0]), .vec_ready(vr[0]), .drv_inp1(d1[0]), .drv_inp2(d2[0]),
    .dut_out(dout0), .rsp_data(rd[0]), .rsp_valid(rv[0]), .rsp_ready(rr[0]),
    .busy(bz[0]), .dbg_state(st[0]));

  pattern_stim_driver #(.VEC_LEN(8), .SETTLE_CYC(3)) u_b (
    .iccad_clk(iccad_clk), .iccad_rst_n(rst_n[1]), .vec_a(va[1]), .vec_b(vb[1]),
    .vec_valid(vv[1]), .vec_ready(vr[1]), .drv_inp1(d1[1]), .drv_inp2(d2[1]),
    .dut_out(dout1), .rsp_data(rd[1]), .rsp_valid(rv[1]), .rsp_ready(rr[1]),
    .busy(bz[1]), .dbg_state(st[1]));

  pattern_stim_driver #(.VEC_LEN(1), .SETTLE_CYC(1)) u_c (
    .iccad_clk(iccad_clk), .iccad_rst_n(c_rst_n), .vec_a(c_va), .vec_b(c_vb),
    .vec_valid(c_vv), .vec_ready(c_vr), .drv_inp1(c_d1), .drv_inp2(c_d2),
    .dut_out(c_dout), .rsp_data(c_rd), .rsp_valid(c_rv), .rsp_ready(c_rr),
    .busy(c_bz), .dbg_state(c_st));

  int n_pass  = 0;
  int n_total = 0;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  task automatic step();
    @(posedge iccad_clk);
    #1;
  endtask

  function automatic int settle_of(input int s);
    return (s == 0) ? 1 : 3;
  endfunction

  // Reference: response is a^b, and after accept edge E0 the pair driven during
  // cycle k is bit k/S; the response appears 8*S edges after E0.
  task automatic run_frame(input int s, input logic [7:0] a, input logic [7:0] b,
                           input logic [7:0] exp, input int exp_lat, input string nm);
    int n = 0;
    int lat = 0;
    bit seq_ok = 1'b1;
    int sc = settle_of(s);
    while (!vr[s] && n < 50) begin step(); n++; end
    check({nm, "_ready"}, 64'(vr[s]), 64'd1);
    va[s] = a; vb[s] = b; vv[s] = 1'b1;
    step();
    vv[s] = 1'b0;
    va[s] = 8'($urandom); vb[s] = 8'($urandom);
    while (!rv[s] && lat < 100) begin
      if (lat / sc < 8) begin
        if (d1[s] !== a[lat / sc] || d2[s] !== b[lat / sc]) seq_ok = 1'b0;
      end else seq_ok = 1'b0;
      step();
      lat++;
    end
    check({nm, "_latency"}, 64'(lat), 64'(exp_lat));
    check({nm, "_drv_seq"}, 64'(seq_ok), 64'd1);
    check({nm, "_rsp_data"}, 64'(rd[s]), 64'(exp));
    check({nm, "_drv_idle"}, 64'({d1[s], d2[s]}), 64'd0);
    rr[s] = 1'b1;
    step();
    rr[s] = 1'b0;
    check({nm, "_rsp_drop"}, 64'({rv[s], vr[s], bz[s]}), 64'b010);
  endtask

  typedef struct {
    int         sel;
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] exp;
    int         lat;
    string      nm;
  } vec_t;

  vec_t tbl [6];

  initial begin
    bit ok;
    int n;
    tbl[0] = '{0, 8'hA5, 8'h0F, 8'hAA, 8,  "basic"};
    tbl[1] = '{1, 8'hFF, 8'h00, 8'hFF, 24, "settle3"};
    tbl[2] = '{0, 8'h3C, 8'hC3, 8'hFF, 8,  "alt"};
    tbl[3] = '{1, 8'h55, 8'h55, 8'h00, 24, "same"};
    tbl[4] = '{0, 8'h00, 8'h00, 8'h00, 8,  "zero"};
    tbl[5] = '{1, 8'h80, 8'h01, 8'h81, 24, "ends"};

    for (int i = 0; i < 2; i++) begin
      rst_n[i] = 1'b0; va[i] = '0; vb[i] = '0; vv[i] = 1'b0; rr[i] = 1'b0;
    end
    c_rst_n = 1'b0; c_va = 1'b0; c_vb = 1'b0; c_vv = 1'b0; c_rr = 1'b0;
    step();
    step();
    for (int i = 0; i < 2; i++) begin
      check("reset_outs", 64'({vr[i], rv[i], bz[i], d1[i], d2[i]}), 64'b10000);
      check("reset_data", 64'(rd[i]), 64'd0);
      check("reset_state", 64'(st[i]), 64'(IDLE));
    end
    rst_n[0] = 1'b1; rst_n[1] = 1'b1; c_rst_n = 1'b1;
    step();

    for (int i = 0; i < 6; i++)
      run_frame(tbl[i].sel, tbl[i].a, tbl[i].b, tbl[i].exp, tbl[i].lat, tbl[i].nm);

    // Backpressure on instance 0
    va[0] = 8'h5A; vb[0] = 8'h33; vv[0] = 1'b1;
    step();
    vv[0] = 1'b0;
    n = 0;
    while (!rv[0] && n < 100) begin step(); n++; end
    check("bp_rsp_data", 64'(rd[0]), 64'h69);
    ok = 1'b1;
    for (int i = 0; i < 10; i++) begin
      vv[0] = 1'b1; va[0] = 8'hFF; vb[0] = 8'h00;
      step();
      if (!(rv[0] === 1'b1 && rd[0] === 8'h69 && vr[0] === 1'b0 && bz[0] === 1'b1)) ok = 1'b0;
    end
    check("bp_hold_stable", 64'(ok), 64'd1);
    rr[0] = 1'b1;
    step();
    rr[0] = 1'b0;
    check("bp_release", 64'({rv[0], vr[0]}), 64'b01);
    check("bp_release_state", 64'(st[0]), 64'(IDLE));
    step();
    vv[0] = 1'b0;
    check("bp_next_accept", 64'({vr[0], bz[0]}), 64'b01);
    n = 0;
    while (!rv[0] && n < 100) begin step(); n++; end
    check("bp_second_data", 64'(rd[0]), 64'hFF);
    rr[0] = 1'b1; step(); rr[0] = 1'b0;

    // Back-to-back with valid and ready held high
    rr[0] = 1'b1;
    va[0] = 8'h01; vb[0] = 8'h00; vv[0] = 1'b1;
    step();
    va[0] = 8'h80;
    n = 0;
    while (!rv[0] && n < 100) begin step(); n++; end
    check("b2b_first", 64'(rd[0]), 64'h01);
    step();
    check("b2b_idle_gap", 64'({st[0], vr[0]}), 64'({IDLE, 1'b1}));
    step();
    check("b2b_restart", 64'(st[0]), 64'(DRIVE));
    n = 0;
    while (!rv[0] && n < 100) begin step(); n++; end
    check("b2b_second", 64'(rd[0]), 64'h80);
    vv[0] = 1'b0;
    step();
    rr[0] = 1'b0;
    check("b2b_drain", 64'(rv[0]), 64'd0);

    // Reset in the middle of a frame
    va[0] = 8'hFF; vb[0] = 8'h00; vv[0] = 1'b1;
    step();
    vv[0] = 1'b0;
    step();
    step();
    rst_n[0] = 1'b0;
    step();
    check("rst_mid_state", 64'(st[0]), 64'(IDLE));
    check("rst_mid_outs", 64'({d1[0], d2[0], rv[0], vr[0], bz[0]}), 64'b00010);
    rst_n[0] = 1'b1;
    ok = 1'b1;
    for (int i = 0; i < 40; i++) begin
      step();
      if (rv[0] !== 1'b0) ok = 1'b0;
    end
    check("rst_mid_no_rsp", 64'(ok), 64'd1);

    // Randomized frames against the model
    for (int i = 0; i < 16; i++) begin
      int s;
      logic [7:0] a, b;
      s = int'($urandom_range(0, 1));
      a = 8'($urandom);
      b = 8'($urandom);
      run_frame(s, a, b, a ^ b, 8 * settle_of(s), "rand");
    end

    // Single-bit configuration
    c_va = 1'b1; c_vb = 1'b1; c_vv = 1'b1;
    step();
    c_vv = 1'b0;
    check("c_drive", 64'({c_d1, c_d2, c_rv, c_vr}), 64'b1100);
    step();
    check("c_rsp", 64'({c_rv, c_rd, c_d1, c_d2}), 64'b1000);
    c_rr = 1'b1; step(); c_rr = 1'b0;
    check("c_done", 64'({c_rv, c_vr, c_bz}), 64'b010);
    c_va = 1'b1; c_vb = 1'b0; c_vv = 1'b1;
    step();
    c_vv = 1'b0;
    step();
    check("c_rsp_one", 64'({c_rv, c_rd}), 64'b11);
    c_rr = 1'b1; step(); c_rr = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
